// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types and width helpers for the CPU instruction-trace buffer.
// TRACE_CYCLE_STAMP_EN adds a cycle stamp field to each trace entry.
package trace_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      FROZEN = 1'b1
   } trace_state_t;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned INST_W_DEF = 32;
   localparam int unsigned CYC_W_DEF  = 32;

`ifdef TRACE_CYCLE_STAMP_EN
   localparam bit STAMP_EN = 1'b1;
`else
   localparam bit STAMP_EN = 1'b0;
`endif

   // Entry width: [stamp], pc, inst
   function automatic int unsigned ent_w(input int unsigned addr_w,
                                         input int unsigned inst_w,
                                         input int unsigned cyc_w);
      return addr_w + inst_w + (STAMP_EN ? cyc_w : 0);
   endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: one synchronous write port and one registered read port.
module trace_ram
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ENT_W = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [ENT_W-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [ENT_W-1:0]         rdata
);

   logic [ENT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value between accepted reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture beside the CPU: circular history, freeze on halt/watchdog, read-back port.
// Define TRACE_CYCLE_STAMP_EN to store the cycle count in the top bits of each entry.
module cpu_trace_buffer
   import trace_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INST_W  = INST_W_DEF,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned CYC_W   = CYC_W_DEF,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     valid,
   input  logic [ADDR_W-1:0]                        pc,
   input  logic [INST_W-1:0]                        inst,
   input  logic                                     halt,
   input  logic                                     clear,
   input  logic                                     rd_en,
   input  logic [$clog2(DEPTH)-1:0]                 rd_idx,
   output logic [ent_w(ADDR_W, INST_W, CYC_W)-1:0]  rd_data,
   output logic                                     rd_valid,
   output logic                                     frozen,
   output logic                                     timeout,
   output logic [$clog2(DEPTH):0]                   count,
   output logic [CYC_W-1:0]                         cycles,
   output logic [CYC_W-1:0]                         retired
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned ENT_W = ent_w(ADDR_W, INST_W, CYC_W);

   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
   localparam logic [CYC_W-1:0] WD_LAST = CYC_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit               WD_EN   = (TIMEOUT != 0);

   trace_state_t     state_q, state_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CYC_W-1:0] cycles_q, cycles_d;
   logic [CYC_W-1:0] retired_q, retired_d;
   logic             timeout_q, timeout_d;
   logic             rd_valid_q, rd_valid_d;
   logic             oob_q, oob_d;
   logic             we, re, wd_hit;
   logic [IDX_W-1:0] raddr;
   logic [ENT_W-1:0] wdata, ram_rdata;

`ifdef TRACE_CYCLE_STAMP_EN
   assign wdata = {cycles_q, pc, inst};
`else
   assign wdata = {pc, inst};
`endif

   // Next-state, counters and read request
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      cycles_d   = cycles_q;
      retired_d  = retired_q;
      timeout_d  = timeout_q;
      we         = 1'b0;
      wd_hit     = WD_EN && (cycles_q == WD_LAST);
      re         = (state_q == FROZEN) && rd_en;
      raddr      = IDX_W'(wr_ptr_q - IDX_W'(count_q) + rd_idx);
      rd_valid_d = re;
      oob_d      = re ? (CNT_W'(rd_idx) >= count_q) : oob_q;

      if (clear && !halt) begin
         state_d   = RUN;
         wr_ptr_d  = '0;
         count_d   = '0;
         cycles_d  = '0;
         retired_d = '0;
         timeout_d = 1'b0;
      end else if (state_q == RUN) begin
         cycles_d = cycles_q + CYC_ONE;
         if (valid) begin
            we        = 1'b1;
            wr_ptr_d  = wr_ptr_q + IDX_ONE;
            retired_d = retired_q + CYC_ONE;
            count_d   = (count_q == FULL) ? count_q : count_q + CNT_ONE;
         end
         if (halt || wd_hit) begin
            state_d = FROZEN;
         end
         if (wd_hit) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         cycles_q   <= '0;
         retired_q  <= '0;
         timeout_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         oob_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         cycles_q   <= cycles_d;
         retired_q  <= retired_d;
         timeout_q  <= timeout_d;
         rd_valid_q <= rd_valid_d;
         oob_q      <= oob_d;
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .ENT_W (ENT_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .re    (re),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   // Out-of-range reads return zero but still complete
   assign rd_data  = oob_q ? '0 : ram_rdata;
   assign rd_valid = rd_valid_q;
   assign frozen   = (state_q == FROZEN);
   assign timeout  = timeout_q;
   assign count    = count_q;
   assign cycles   = cycles_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_cpu_trace_buffer;
   import trace_pkg::*;

   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned CW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned EW    = ent_w(AW, IW, CW);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid = 1'b0, halt = 1'b0, clear = 1'b0, rd_en = 1'b0;
   logic [AW-1:0] pc = '0;
   logic [IW-1:0] inst = '0;
   logic [3:0]    rd_idx = '0;

   logic [EW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1, frozen0, frozen1, timeout0, timeout1;
   logic [4:0]    count0, count1;
   logic [CW-1:0] cycles0, cycles1, retired0, retired1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_trace_buffer #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .CYC_W(CW), .TIMEOUT(0)) dut0 (
      .clk(clk), .rst(rst), .valid(valid), .pc(pc), .inst(inst), .halt(halt), .clear(clear),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data0), .rd_valid(rd_valid0), .frozen(frozen0),
      .timeout(timeout0), .count(count0), .cycles(cycles0), .retired(retired0));

   cpu_trace_buffer #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .CYC_W(CW), .TIMEOUT(8)) dut1 (
      .clk(clk), .rst(rst), .valid(valid), .pc(pc), .inst(inst), .halt(halt), .clear(clear),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data1), .rd_valid(rd_valid1), .frozen(frozen1),
      .timeout(timeout1), .count(count1), .cycles(cycles1), .retired(retired1));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model for dut0: history as a queue, oldest first
   logic [EW-1:0] mq[$];
   bit            m_frozen = 1'b0, m_timeout = 1'b0, m_rdv = 1'b0;
   logic [EW-1:0] m_rdd = '0;
   logic [CW-1:0] m_cycles = '0, m_retired = '0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            m_frozen = 1'b0; m_timeout = 1'b0; m_rdv = 1'b0;
            m_rdd = '0; m_cycles = '0; m_retired = '0;
         end else begin
            m_rdv = m_frozen && rd_en;
            if (m_rdv) m_rdd = (int'(rd_idx) < mq.size()) ? mq[rd_idx] : '0;
            if (clear && !halt) begin
               mq.delete();
               m_frozen = 1'b0; m_timeout = 1'b0; m_cycles = '0; m_retired = '0;
            end else if (!m_frozen) begin
               if (valid) begin
`ifdef TRACE_CYCLE_STAMP_EN
                  mq.push_back({m_cycles, pc, inst});
`else
                  mq.push_back({pc, inst});
`endif
                  if (mq.size() > DEPTH) void'(mq.pop_front());
                  m_retired = m_retired + 1;
               end
               m_cycles = m_cycles + 1;
               if (halt) m_frozen = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of dut0 against the model
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("m_frozen",   128'(frozen0),   128'(m_frozen));
            chk("m_timeout",  128'(timeout0),  128'(m_timeout));
            chk("m_count",    128'(count0),    128'(mq.size()));
            chk("m_cycles",   128'(cycles0),   128'(m_cycles));
            chk("m_retired",  128'(retired0),  128'(m_retired));
            chk("m_rd_valid", 128'(rd_valid0), 128'(m_rdv));
            chk("m_rd_data",  128'(rd_data0),  128'(m_rdd));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [AW-1:0] p);
      valid = 1'b1; pc = p; inst = 32'hA000_0000 | p;
      tick();
      valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx);
      rd_en = 1'b1; rd_idx = idx;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_frozen"},  128'(frozen0),   '0);
      chk({nm, "_timeout"}, 128'(timeout0),  '0);
      chk({nm, "_count"},   128'(count0),    '0);
      chk({nm, "_cycles"},  128'(cycles0),   '0);
      chk({nm, "_retired"}, 128'(retired0),  '0);
      chk({nm, "_rdv"},     128'(rd_valid0), '0);
      chk({nm, "_rdd"},     128'(rd_data0),  '0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      chk("reset_frozen1", 128'(frozen1), '0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      // Watchdog on dut1
      repeat (7) tick();
      chk("wd_not_yet", 128'(frozen1), '0);
      chk("wd_cyc7",    128'(cycles1), 128'(7));
      tick();
      chk("wd_frozen",  128'(frozen1),  128'(1));
      chk("wd_timeout", 128'(timeout1), 128'(1));
      chk("wd_cyc8",    128'(cycles1),  128'(8));
      clear = 1'b1; tick(); clear = 1'b0;
      chk("wd_clr_frozen",  128'(frozen1),  '0);
      chk("wd_clr_timeout", 128'(timeout1), '0);
      chk("wd_clr_cycles",  128'(cycles1),  '0);
      chk("wd_clr_retired", 128'(retired1), '0);

      // Five retires then halt
      for (int i = 0; i < 5; i++) retire(32'(4 * i));
      halt = 1'b1; tick(); halt = 1'b0;
      chk("t1_frozen", 128'(frozen0), 128'(1));
      chk("t1_count",  128'(count0),  128'(5));
      rd_en = 1'b1; rd_idx = 4'd0; tick();
      chk("t1_rd0_pc", 128'(rd_data0[IW +: AW]), 128'h0);
      rd_idx = 4'd4; tick(); rd_en = 1'b0;
      chk("t1_rd4_pc", 128'(rd_data0[IW +: AW]), 128'h10);
      chk("t1_rd4_v",  128'(rd_valid0), 128'(1));
      tick();
      chk("t1_idle_v",    128'(rd_valid0), '0);
      chk("t1_hold_data", 128'(rd_data0[IW +: AW]), 128'h10);

      // Wraparound: 20 retires into 16 entries
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 20; i++) retire(32'(4 * i));
      halt = 1'b1; tick(); halt = 1'b0;
      chk("t2_count",   128'(count0),   128'(16));
      chk("t2_retired", 128'(retired0), 128'(20));
      rd(4'd0);
      chk("t2_rd0_pc", 128'(rd_data0[IW +: AW]), 128'h10);
      rd(4'd15);
      chk("t2_rd15_pc", 128'(rd_data0[IW +: AW]), 128'h4C);

      // Halt together with valid, then ignored retires
      clear = 1'b1; tick(); clear = 1'b0;
      retire(32'h1C); retire(32'h20);
      halt = 1'b1; retire(32'h24); halt = 1'b0;
      chk("t3_frozen", 128'(frozen0), 128'(1));
      for (int i = 0; i < 3; i++) retire(32'h100);
      chk("t3_retired", 128'(retired0), 128'(3));
      chk("t3_count",   128'(count0),   128'(3));
      rd(4'd2);
      chk("t3_rd2_pc", 128'(rd_data0[IW +: AW]), 128'h24);
      rd(4'd7);
      chk("t3_oob_data",  128'(rd_data0),  '0);
      chk("t3_oob_valid", 128'(rd_valid0), 128'(1));
      halt = 1'b1; clear = 1'b1; tick(); halt = 1'b0; clear = 1'b0;
      chk("t3_clr_halt_frozen", 128'(frozen0), 128'(1));
      chk("t3_clr_halt_count",  128'(count0),  128'(3));

      // Reads in RUN are not honoured
      clear = 1'b1; tick(); clear = 1'b0;
      rd_en = 1'b1; rd_idx = 4'd0; tick();
      chk("t4_run_rdv_a", 128'(rd_valid0), '0);
      tick(); rd_en = 1'b0;
      chk("t4_run_rdv_b", 128'(rd_valid0), '0);

      // Asynchronous reset mid-capture
      for (int i = 0; i < 9; i++) retire(32'(4 * i));
      chk("t5_count9", 128'(count0), 128'(9));
      #2 rst = 1'b1;
      #1 chk_zero("t5_async");
      @(posedge clk); #1 rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable instruction-trace capture unit that sits beside `SingleCycleCPU` and records the last DEPTH retired instructions as (PC, instruction word) pairs in a circular buffer. It freezes on `halt` or on a watchdog timeout, then exposes the captured history through a registered read port. The bench and on-board debug logic use it in place of per-cycle `$monitor` printing. It is parametrised in PC width, instruction width, depth and timeout.

## Interface
- `ADDR_W`, 32, PC width in bits.
- `INST_W`, 32, instruction word width in bits.
- `DEPTH`, 16, number of trace entries; power of two, at least 2.
- `CYC_W`, 32, width of the cycle and retire counters.
- `TIMEOUT`, 0, watchdog limit in cycles; 0 disables the watchdog.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid`  in  1  an instruction retires this cycle.
- `pc`  in  ADDR_W  PC of the retiring instruction.
- `inst`  in  INST_W  retiring instruction word.
- `halt`  in  1  CPU halt, level-sensitive.
- `clear`  in  1  synchronous restart of capture.
- `rd_en`  in  1  read request.
- `rd_idx`  in  $clog2(DEPTH)  entry index; 0 is the oldest entry.
- `rd_data`  out  ENT_W  entry read out. ENT_W is ADDR_W+INST_W, plus CYC_W when `TRACE_CYCLE_STAMP_EN` is defined.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `frozen`  out  1  capture has stopped.
- `timeout`  out  1  the watchdog caused the freeze (sticky).
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `cycles`  out  CYC_W  cycles spent in RUN.
- `retired`  out  CYC_W  instructions retired in RUN.

## Operation
- State machine has two states, RUN and FROZEN. Reset enters RUN.
- Reset values: all outputs are 0, `wr_ptr` is 0. Entry contents are don't-care.
- RUN, every cycle:
  - `cycles` increments, wrapping modulo 2^CYC_W.
  - When `valid` is high, write {pc, inst} to `mem[wr_ptr]`, increment `wr_ptr` (wrapping modulo DEPTH), increment `retired`, and increment `count`, saturating at DEPTH.
  - When `count` equals DEPTH, the write overwrites the oldest entry.
- RUN to FROZEN:
  - On `halt`=1. An entry that is `valid` in the same cycle is still captured.
  - On the watchdog: TIMEOUT≠0 and `cycles`==TIMEOUT-1. That cycle's entry is captured and `timeout` is set to 1.
- FROZEN:
  - No writes. All counters hold.
  - `valid`, `pc` and `inst` are ignored.
- `clear`:
  - Acts in either state only when `halt`=0.
  - Sets `count`, `wr_ptr`, `cycles`, `retired` and `timeout` to 0 and enters RUN.
  - A `valid` in the same cycle is discarded.
  - `clear` with `halt`=1 is ignored; the halt freeze takes priority.
- Reads:
  - Reads are honored only in FROZEN. `rd_en` in RUN produces no `rd_valid`.
  - Physical address = (`wr_ptr` - `count` + `rd_idx`) mod DEPTH.
  - If `rd_idx` >= `count`, `rd_data` is 0 and `rd_valid` is still 1.
- Entry layout, MSB to LSB: [stamp], pc, inst.
- Reset asserted mid-operation returns the block to the reset state immediately, regardless of state.

## Timing
- Capture completes at the rising edge of the cycle in which `valid` is high.
- `count`, `retired` and `cycles` reflect that edge.
- `frozen` rises at the edge that samples `halt`=1 or the timeout condition.
- Read latency is 1 cycle: `rd_en` sampled at edge N gives `rd_data`/`rd_valid` after edge N.
  - `rd_valid` is high for exactly one cycle per accepted request.
  - Back-to-back reads give one result per cycle.
- `rd_data` holds its last value while `rd_valid` is 0.

## Configuration
- `TRACE_CYCLE_STAMP_EN` defined:
  - Each entry also stores the `cycles` value at capture in the top CYC_W bits.
  - ENT_W = CYC_W+ADDR_W+INST_W.
- `TRACE_CYCLE_STAMP_EN` undefined:
  - There is no stamp field and ENT_W = ADDR_W+INST_W.
  - `cycles` is still counted and output.

## Structure
- Package `trace_pkg`:
  - state enum `trace_state_t` {RUN, FROZEN}
  - function `ent_w(addr_w, inst_w, cyc_w)` returning ENT_W, honoring the macro
  - localparam defaults for ADDR_W, INST_W and CYC_W
- Sub-module `trace_ram`:
  - DEPTH × ENT_W storage
  - one synchronous write port
  - one registered read port, giving the 1-cycle read latency
- The top level holds the FSM, pointers, counters, watchdog and address arithmetic.

## Test plan
- Reset, then 5 `valid` cycles with pc=0x0,0x4,…,0x10, then `halt` → `frozen`=1, `count`=5; `rd_idx`=0 returns pc=0x0; `rd_idx`=4 returns pc=0x10.
- DEPTH=16, 20 retires pc=0x0…0x4C, then `halt` → `count`=16, `retired`=20; `rd_idx`=0 returns pc=0x10; `rd_idx`=15 returns pc=0x4C.
- `halt` and `valid` in the same cycle with pc=0x24 → entry captured, `frozen`=1; following `valid` pulses are ignored and `retired` is unchanged.
- TIMEOUT=8, no `halt` → `frozen`=1 and `timeout`=1 after edge 8, `cycles`=8. Then `clear`=1 → RUN with all counters 0 and `timeout`=0.
- `rd_idx`=7 with `count`=3 → `rd_data`=0, `rd_valid`=1. `rd_en` in RUN → `rd_valid` stays 0.
- Assert `rst` mid-capture at `count`=9 → all outputs 0 immediately, without waiting for a clock edge.
